imem_boot_monitor: RTL and testbench
====================================

Name: imem_boot_monitor

Overview:
- Self-checking boot and run controller for the MIPS core.
- Streams a program image into instruction memory while holding the core in reset, then releases it.
- Watches the data-memory write bus for a completion store, a window of result words and a cycle-budget timeout.
- Sits between the program source (bench or host link) and the core's `imem` write port, `reset` input and `dmem` write bus.
- Generalises the fixed-image, fixed-duration run flow to any width, depth, watch-window size and pass criterion.

Parameters:
- DW, 32, data word width of the `imem`/`dmem` buses.
- AW, 7, word-address width of `imem`/`dmem`.
- NUM_WATCH, 10, number of consecutive `dmem` words captured.
- WATCH_BASE, 100, first watched `dmem` word address.
- DONE_ADDR, 127, `dmem` address whose store ends the run.
- PASS_VALUE, 1, value at DONE_ADDR meaning pass.
- RELEASE_DLY, 2, cycles the core stays in reset after loading ends (≥1).
- CW, 16, width of the cycle counter.
- TIMEOUT, 1000, run-cycle budget (< 2^CW).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load. Ignored in LOAD, HOLD and RUN.
- ld_valid  in  1  program word valid.
- ld_ready  out  1  controller accepts a program word.
- ld_data  in  DW  program word.
- ld_last  in  1  marks the final program word.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  AW  instruction-memory write address.
- imem_wdata  out  DW  instruction-memory write data.
- cpu_reset  out  1  active-high reset to the core.
- dmem_we  in  1  core data-memory write strobe (observed only).
- dmem_addr  in  AW  core data-memory write address.
- dmem_wdata  in  DW  core data-memory write data.
- busy  out  1  high in LOAD, HOLD and RUN.
- done  out  1  completion store seen.
- pass  out  1  completion value equalled PASS_VALUE.
- timeout  out  1  run-cycle budget exhausted.
- load_err  out  1  image exceeded the `imem` depth.
- result  out  DW  value stored to DONE_ADDR.
- cycles  out  CW  run cycles elapsed.
- load_count  out  AW+1  words loaded.
- watch_data  out  NUM_WATCH*DW  captured words; word i is at bits [i*DW +: DW].

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=IDLE, cpu_reset=1.
  - All flags, result, cycles, load_count and watch registers are 0.
  - Applying reset mid-load or mid-run aborts immediately; no further `imem` writes occur.
- States: IDLE, LOAD, HOLD, RUN, DONE, TOUT. cpu_reset=1 in every state except RUN.
- IDLE/DONE/TOUT + start → LOAD. Entering LOAD does the following:
  - Clears the load pointer, load_count, cycles, result, all flags and the watch registers.
- LOAD:
  - ld_ready=1.
  - imem_we = ld_valid & ld_ready (combinational); imem_addr = pointer; imem_wdata = ld_data.
  - Each accepted word increments the pointer and load_count.
  - Accepting a word with ld_last=1 → HOLD.
  - Accepting the word at address 2^AW−1 with ld_last=0 → HOLD with load_err=1. That word is written; any further stream words are not accepted.
  - ld_valid=0 simply stalls; there is no timeout in LOAD.
- HOLD:
  - ld_ready=0.
  - Counts RELEASE_DLY cycles, then → RUN. cpu_reset falls on the first RUN cycle.
- RUN:
  - cycles increments every cycle.
  - Any dmem_we with WATCH_BASE ≤ dmem_addr < WATCH_BASE+NUM_WATCH loads watch word (dmem_addr−WATCH_BASE) with dmem_wdata on that clock edge.
  - A store to DONE_ADDR → DONE:
    - result=dmem_wdata, pass=(dmem_wdata==PASS_VALUE), done=1.
    - cycles freezes at the count including that cycle.
  - cycles reaching TIMEOUT with no done store → TOUT, timeout=1, pass=0.
  - A done store in the same cycle cycles reaches TIMEOUT: done wins; timeout stays 0.
  - If DONE_ADDR also lies inside the watch window, both the watch word and result update.
- DONE/TOUT:
  - Hold all outputs.
  - Watch registers ignore further `dmem` writes.
  - start restarts at LOAD.
- dmem writes are ignored in every state except RUN.
- Width rules:
  - Comparisons use full DW.
  - cycles never wraps, because TIMEOUT < 2^CW.
  - load_count holds 2^AW after a full-depth load.

Test Plan:
- Nominal boot: after reset, pulse start, stream 5 words 0x20010005.., ld_last on word 5 → `imem` addresses 0..4 written in order, load_count=5, cpu_reset stays 1 for 2 cycles after the last accept, then 0.
- Pass run: in RUN, drive dmem_we to addresses 100..109 with 10..100, then store 1 to address 127 → done=1, pass=1, result=1, watch_data word 2 = 30, cpu_reset=1 again.
- Fail and timeout: store 7 to address 127 → done=1, pass=0. New run with no done store → timeout=1 with cycles=1000; a store at cycle 1000 → done=1, timeout=0.
- Overflow: with AW=3, stream 9 words and no ld_last → 8 writes to addresses 0..7, load_err=1, HOLD entered, 9th word never accepted (ld_ready=0).
- Backpressure and restart: ld_valid toggling every other cycle → no gaps or duplicates in `imem` addresses; start pulse during RUN → ignored; start pulse in DONE → flags, watch registers and counters cleared, LOAD re-entered.
- Async reset: drop `reset` mid-LOAD between clock edges → cpu_reset=1 and imem_we=0 immediately, all outputs 0; after release, state=IDLE.

Source files
------------

// File: rtl/imem_boot_monitor.sv
// Boot and run controller for the MIPS core. It streams a program image into imem with the core
// held in reset, releases the core, then watches the dmem write bus for results, completion or timeout.
module imem_boot_monitor #(
   parameter int DW          = 32,
   parameter int AW          = 7,
   parameter int NUM_WATCH   = 10,
   parameter int WATCH_BASE  = 100,
   parameter int DONE_ADDR   = 127,
   parameter int PASS_VALUE  = 1,
   parameter int RELEASE_DLY = 2,
   parameter int CW          = 16,
   parameter int TIMEOUT     = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [DW-1:0]           ld_data,
   input  logic                    ld_last,
   output logic                    imem_we,
   output logic [AW-1:0]           imem_addr,
   output logic [DW-1:0]           imem_wdata,
   output logic                    cpu_reset,
   input  logic                    dmem_we,
   input  logic [AW-1:0]           dmem_addr,
   input  logic [DW-1:0]           dmem_wdata,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic                    load_err,
   output logic [DW-1:0]           result,
   output logic [CW-1:0]           cycles,
   output logic [AW:0]             load_count,
   output logic [NUM_WATCH*DW-1:0] watch_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DONE,
      S_TOUT
   } state_t;

   localparam int              DLYW      = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
   localparam logic [DLYW-1:0] DLY_LAST  = DLYW'(RELEASE_DLY - 1);
   localparam logic [CW-1:0]   CYC_LIMIT = CW'(TIMEOUT);
   localparam logic [AW-1:0]   PTR_MAX   = '1;
   localparam logic [AW-1:0]   DONE_WORD = AW'(DONE_ADDR);
   localparam logic [DW-1:0]   PASS_WORD = DW'(PASS_VALUE);
   localparam logic [31:0]     WIN_LO    = 32'(WATCH_BASE);
   localparam logic [31:0]     WIN_HI    = 32'(WATCH_BASE + NUM_WATCH);

   state_t          state_q, state_d;
   logic [AW:0]     load_count_q, load_count_d;
   logic [DLYW-1:0] dly_q, dly_d;
   logic [CW-1:0]   cycles_q, cycles_d;
   logic [DW-1:0]   result_q, result_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            timeout_q, timeout_d;
   logic            load_err_q, load_err_d;
   logic [DW-1:0]   watch_q [NUM_WATCH];
   logic [DW-1:0]   watch_d [NUM_WATCH];

   logic [31:0]     addr_ext;
   logic [31:0]     watch_idx;
   logic            watch_hit;
   logic            done_hit;
   logic [CW-1:0]   cyc_next;

   assign addr_ext  = 32'(dmem_addr);
   assign watch_idx = addr_ext - WIN_LO;
   assign watch_hit = dmem_we && (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
   assign done_hit  = dmem_we && (dmem_addr == DONE_WORD);
   assign cyc_next  = cycles_q + CW'(1);

   // The load pointer is the low part of load_count; the extra top bit lets a
   // full-depth load report 2^AW words.
   assign ld_ready   = (state_q == S_LOAD);
   assign imem_we    = ld_valid & ld_ready;
   assign imem_addr  = load_count_q[AW-1:0];
   assign imem_wdata = ld_data;
   assign cpu_reset  = (state_q != S_RUN);
   assign busy       = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);

   assign done       = done_q;
   assign pass       = pass_q;
   assign timeout    = timeout_q;
   assign load_err   = load_err_q;
   assign result     = result_q;
   assign cycles     = cycles_q;
   assign load_count = load_count_q;

   for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch_out
      assign watch_data[g*DW +: DW] = watch_q[g];
   end

   always_comb begin
      // NOTE: every next-state variable takes its hold value first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      load_count_d = load_count_q;
      dly_d        = dly_q;
      cycles_d     = cycles_q;
      result_d     = result_q;
      done_d       = done_q;
      pass_d       = pass_q;
      timeout_d    = timeout_q;
      load_err_d   = load_err_q;
      watch_d      = watch_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_TOUT: begin
            if (start) begin
               state_d      = S_LOAD;
               load_count_d = '0;
               cycles_d     = '0;
               result_d     = '0;
               done_d       = 1'b0;
               pass_d       = 1'b0;
               timeout_d    = 1'b0;
               load_err_d   = 1'b0;
               for (int i = 0; i < NUM_WATCH; i++) watch_d[i] = '0;
            end
         end

         S_LOAD: begin
            if (ld_valid) begin
               load_count_d = load_count_q + (AW+1)'(1);
               if (ld_last) begin
                  state_d = S_HOLD;
                  dly_d   = '0;
               end else if (load_count_q[AW-1:0] == PTR_MAX) begin
                  // The last imem word was just written and the stream has not ended.
                  state_d    = S_HOLD;
                  dly_d      = '0;
                  load_err_d = 1'b1;
               end
            end
         end

         S_HOLD: begin
            if (dly_q == DLY_LAST) state_d = S_RUN;
            else                   dly_d   = dly_q + DLYW'(1);
         end

         S_RUN: begin
            cycles_d = cyc_next;
            for (int i = 0; i < NUM_WATCH; i++) begin
               if (watch_hit && (watch_idx == 32'(i))) watch_d[i] = dmem_wdata;
            end
            // A completion store in the budget's final cycle still counts as done.
            if (done_hit) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               result_d = dmem_wdata;
               pass_d   = (dmem_wdata == PASS_WORD);
            end else if (cyc_next == CYC_LIMIT) begin
               state_d   = S_TOUT;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         load_count_q <= '0;
         dly_q        <= '0;
         cycles_q     <= '0;
         result_q     <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         load_err_q   <= 1'b0;
         // NOTE: the watch words are visible outputs, so this small register
         // array is reset like any other flop rather than left as RAM.
         for (int i = 0; i < NUM_WATCH; i++) watch_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         dly_q        <= dly_d;
         cycles_q     <= cycles_d;
         result_q     <= result_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         timeout_q    <= timeout_d;
         load_err_q   <= load_err_d;
         for (int i = 0; i < NUM_WATCH; i++) watch_q[i] <= watch_d[i];
      end
   end

endmodule

// File: tb/tb_imem_boot_monitor.sv
// Randomised bench for imem_boot_monitor: a phase-level reference model is compared against
// the DUT on every cycle, with hand-computed literal checks for the key scenarios.
module tb_imem_boot_monitor;

   localparam int DW = 32, AW = 7, NW = 10, WB = 100, DA = 127, TO = 1000, RD = 2, CW = 16;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic ld_valid = 1'b0, ld_last = 1'b0;
   logic [DW-1:0] ld_data = '0;
   logic dmem_we = 1'b0;
   logic [AW-1:0] dmem_addr = '0;
   logic [DW-1:0] dmem_wdata = '0;
   logic ld_ready, imem_we, cpu_reset, busy, done, pass, timeout, load_err;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata, result;
   logic [CW-1:0] cycles;
   logic [AW:0] load_count;
   logic [NW*DW-1:0] watch_data;

   // Small-depth instance used only for the imem overflow scenario.
   logic s_start = 1'b0, s_ld_valid = 1'b0, s_ld_last = 1'b0;
   logic [DW-1:0] s_ld_data = '0;
   logic s_dmem_we = 1'b0;
   logic [2:0] s_dmem_addr = '0;
   logic [DW-1:0] s_dmem_wdata = '0;
   logic s_ld_ready, s_imem_we, s_cpu_reset, s_busy, s_done, s_pass, s_timeout, s_load_err;
   logic [2:0] s_imem_addr;
   logic [DW-1:0] s_imem_wdata, s_result;
   logic [CW-1:0] s_cycles;
   logic [3:0] s_load_count;
   logic [2*DW-1:0] s_watch;

   always #5 clk = ~clk;

   imem_boot_monitor #(
      .DW(DW), .AW(AW), .NUM_WATCH(NW), .WATCH_BASE(WB), .DONE_ADDR(DA),
      .PASS_VALUE(1), .RELEASE_DLY(RD), .CW(CW), .TIMEOUT(TO)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout), .load_err(load_err),
      .result(result), .cycles(cycles), .load_count(load_count), .watch_data(watch_data)
   );

   imem_boot_monitor #(
      .DW(DW), .AW(3), .NUM_WATCH(2), .WATCH_BASE(2), .DONE_ADDR(7),
      .PASS_VALUE(1), .RELEASE_DLY(RD), .CW(CW), .TIMEOUT(TO)
   ) u_small (
      .clk(clk), .reset(reset), .start(s_start),
      .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_data(s_ld_data), .ld_last(s_ld_last),
      .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .cpu_reset(s_cpu_reset),
      .dmem_we(s_dmem_we), .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata),
      .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout), .load_err(s_load_err),
      .result(s_result), .cycles(s_cycles), .load_count(s_load_count), .watch_data(s_watch)
   );

   int n_checks = 0, n_errors = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (phase level) ----------------
   typedef enum int {M_IDLE, M_LOAD, M_HOLD, M_RUN, M_DONE, M_TOUT} mphase_t;
   mphase_t m_ph;
   int m_count, m_hold, m_cycles;
   logic [DW-1:0] m_result;
   bit m_done, m_pass, m_tout, m_err;
   logic [DW-1:0] m_watch [NW];
   logic [NW*DW-1:0] exp_watch;

   always_comb begin
      exp_watch = '0;
      for (int i = 0; i < NW; i++) exp_watch[i*DW +: DW] = m_watch[i];
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ph <= M_IDLE; m_count <= 0; m_hold <= 0; m_cycles <= 0; m_result <= '0;
         m_done <= 0; m_pass <= 0; m_tout <= 0; m_err <= 0;
         for (int i = 0; i < NW; i++) m_watch[i] <= '0;
      end else begin
         case (m_ph)
            M_IDLE, M_DONE, M_TOUT: if (start) begin
               m_ph <= M_LOAD; m_count <= 0; m_cycles <= 0; m_result <= '0;
               m_done <= 0; m_pass <= 0; m_tout <= 0; m_err <= 0;
               for (int i = 0; i < NW; i++) m_watch[i] <= '0;
            end
            M_LOAD: if (ld_valid) begin
               m_count <= m_count + 1;
               if (ld_last || (m_count + 1 == DEPTH)) begin
                  m_ph <= M_HOLD; m_hold <= RD; m_err <= !ld_last;
               end
            end
            M_HOLD: begin
               m_hold <= m_hold - 1;
               if (m_hold == 1) m_ph <= M_RUN;
            end
            M_RUN: begin
               m_cycles <= m_cycles + 1;
               if (dmem_we && int'(dmem_addr) >= WB && int'(dmem_addr) < WB + NW)
                  m_watch[int'(dmem_addr) - WB] <= dmem_wdata;
               if (dmem_we && int'(dmem_addr) == DA) begin
                  m_ph <= M_DONE; m_done <= 1; m_result <= dmem_wdata; m_pass <= (dmem_wdata == 32'd1);
               end else if (m_cycles + 1 == TO) begin
                  m_ph <= M_TOUT; m_tout <= 1; m_pass <= 0;
               end
            end
            default: m_ph <= M_IDLE;
         endcase
      end
   end

   // ---------------- per-cycle comparison ----------------
   logic [AW-1:0] wr_addr_q [$];
   logic [DW-1:0] wr_data_q [$];
   logic [2:0]    s_log [$];

   always @(negedge clk) begin
      if (reset) begin
         check("cmp_cpu_reset", cpu_reset, m_ph != M_RUN);
         check("cmp_busy", busy, m_ph == M_LOAD || m_ph == M_HOLD || m_ph == M_RUN);
         check("cmp_ld_ready", ld_ready, m_ph == M_LOAD);
         check("cmp_imem_we", imem_we, m_ph == M_LOAD && ld_valid);
         if (m_ph == M_LOAD && ld_valid) begin
            check("cmp_imem_addr", imem_addr, m_count % DEPTH);
            check("cmp_imem_wdata", imem_wdata, ld_data);
         end
         check("cmp_done", done, m_done);
         check("cmp_pass", pass, m_pass);
         check("cmp_timeout", timeout, m_tout);
         check("cmp_load_err", load_err, m_err);
         check("cmp_result", result, m_result);
         check("cmp_cycles", cycles, m_cycles);
         check("cmp_load_count", load_count, m_count);
         check("cmp_watch", watch_data, exp_watch);
         if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
         end
         if (s_imem_we) s_log.push_back(s_imem_addr);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // mode 0: always valid, 1: valid every other cycle, 2: random valid
   task automatic load_image(input int n, input bit with_last, input int mode, input bit seq,
                             input logic [DW-1:0] base);
      int sent = 0, budget = 0;
      bit v;
      while (sent < n && m_ph == M_LOAD && budget < 2000) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : ($urandom_range(0, 1) == 1);
         ld_valid = v;
         ld_data  = seq ? base + DW'(sent) : DW'($urandom);
         ld_last  = with_last && (sent == n - 1);
         tick();
         if (v) sent++;
         budget++;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (budget >= 2000) check("load_budget_expired", 1, 0);
   endtask

   task automatic wait_run();
      int k = 0;
      while (m_ph != M_RUN && k < 100) begin tick(); k++; end
      if (k >= 100) check("wait_run_expired", 1, 0);
   endtask

   task automatic noise(input bit bias);
      dmem_we = 1'($urandom_range(0, 1));
      if (bias && $urandom_range(0, 1) == 1) dmem_addr = AW'(WB + $urandom_range(0, NW - 1));
      else dmem_addr = AW'($urandom_range(0, DA - 1));
      dmem_wdata = DW'($urandom);
   endtask

   task automatic store(input int a, input logic [DW-1:0] d);
      dmem_we = 1'b1; dmem_addr = AW'(a); dmem_wdata = d;
      tick();
      dmem_we = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #2;
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_load_count", load_count, 0);
      check("rst_watch", watch_data, 0);
      reset = 1'b1;
      tick();

      // Nominal boot: five sequential words, release two cycles after the last accept.
      wr_addr_q.delete(); wr_data_q.delete();
      pulse_start();
      load_image(5, 1, 0, 1, 32'h2001_0005);
      @(negedge clk); check("nom_hold1_cpu_reset", cpu_reset, 1);
      @(negedge clk); check("nom_hold2_cpu_reset", cpu_reset, 1);
      @(negedge clk); check("nom_run_cpu_reset", cpu_reset, 0);
      check("nom_load_count", load_count, 5);
      check("nom_nwrites", wr_addr_q.size(), 5);
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         check("nom_addr", wr_addr_q[i], i);
         check("nom_data", wr_data_q[i], 32'h2001_0005 + i);
      end
      @(posedge clk); #2;

      // Pass run with the watch window filled and a start pulse that must be ignored.
      for (int i = 0; i < NW; i++) begin
         store(WB + i, DW'(10 * (i + 1)));
         if (i == 4) begin
            pulse_start();
            check("run_start_ignored_busy", busy, 1);
            check("run_start_ignored_cpu_reset", cpu_reset, 0);
         end
      end
      store(DA, 32'd1);
      check("pass_done", done, 1);
      check("pass_pass", pass, 1);
      check("pass_result", result, 1);
      check("pass_watch2", watch_data[2*DW +: DW], 30);
      check("pass_watch9", watch_data[9*DW +: DW], 100);
      check("pass_cpu_reset", cpu_reset, 1);
      for (int i = 0; i < 6; i++) begin noise(1); tick(); end
      dmem_we = 1'b0;
      check("done_watch2_frozen", watch_data[2*DW +: DW], 30);

      // Restart from DONE, toggling backpressure, then a failing completion value.
      wr_addr_q.delete(); wr_data_q.delete();
      pulse_start();
      check("restart_busy", busy, 1);
      check("restart_done", done, 0);
      check("restart_result", result, 0);
      check("restart_cycles", cycles, 0);
      check("restart_load_count", load_count, 0);
      check("restart_watch", watch_data, 0);
      load_image(12, 1, 1, 0, '0);
      check("bp_nwrites", wr_addr_q.size(), 12);
      for (int i = 0; i < wr_addr_q.size(); i++) check("bp_addr", wr_addr_q[i], i);
      wait_run();
      for (int i = 0; i < 20; i++) begin noise(1); tick(); end
      store(DA, 32'd7);
      check("fail_done", done, 1);
      check("fail_pass", pass, 0);
      check("fail_result", result, 7);

      // Timeout: no completion store for the whole budget.
      pulse_start();
      load_image(8, 1, 2, 0, '0);
      wait_run();
      k = 0;
      while (m_ph == M_RUN && k < 1100) begin noise(1); tick(); k++; end
      dmem_we = 1'b0;
      check("tout_timeout", timeout, 1);
      check("tout_cycles", cycles, 1000);
      check("tout_done", done, 0);
      check("tout_pass", pass, 0);

      // Completion store in the very cycle the budget runs out: done wins.
      pulse_start();
      load_image(3, 1, 0, 0, '0);
      wait_run();
      k = 0;
      while (m_cycles < TO - 1 && k < 1100) begin noise(0); tick(); k++; end
      store(DA, 32'd1);
      check("edge_done", done, 1);
      check("edge_timeout", timeout, 0);
      check("edge_cycles", cycles, 1000);
      check("edge_pass", pass, 1);

      // Full-depth stream with no last marker: overflow at 2^AW words.
      wr_addr_q.delete(); wr_data_q.delete();
      pulse_start();
      load_image(DEPTH + 1, 0, 0, 0, '0);
      ld_valid = 1'b1; ld_data = DW'($urandom);
      check("ovf_ld_ready", ld_ready, 0);
      check("ovf_imem_we", imem_we, 0);
      check("ovf_load_err", load_err, 1);
      check("ovf_load_count", load_count, DEPTH);
      tick();
      ld_valid = 1'b0;
      check("ovf_nwrites", wr_addr_q.size(), DEPTH);
      for (int i = 0; i < wr_addr_q.size(); i++) check("ovf_addr", wr_addr_q[i], i);
      wait_run();
      store(DA, 32'd1);

      // Random sessions.
      for (int s = 0; s < 5; s++) begin
         pulse_start();
         load_image($urandom_range(1, 40), 1, 2, 0, '0);
         wait_run();
         k = $urandom_range(5, 60);
         for (int i = 0; i < k && m_ph == M_RUN; i++) begin noise(1); tick(); end
         dmem_we = 1'b0;
         if (m_ph == M_RUN) store(DA, DW'($urandom_range(0, 2)));
      end

      // Asynchronous reset between clock edges in the middle of a load.
      pulse_start();
      ld_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin ld_data = DW'($urandom); tick(); end
      #1 reset = 1'b0;
      #1;
      check("arst_cpu_reset", cpu_reset, 1);
      check("arst_imem_we", imem_we, 0);
      check("arst_ld_ready", ld_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_load_count", load_count, 0);
      check("arst_flags", {done, pass, timeout, load_err}, 0);
      check("arst_result", result, 0);
      check("arst_cycles", cycles, 0);
      @(negedge clk); check("arst_imem_we_held", imem_we, 0);
      @(posedge clk); #2;
      ld_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("arst_idle_busy", busy, 0);
      check("arst_idle_cpu_reset", cpu_reset, 1);
      check("arst_idle_ld_ready", ld_ready, 0);
      @(posedge clk); #2;

      // Overflow on the 8-word instance: nine offered words, eight written.
      s_log.delete();
      s_start = 1'b1; tick(); s_start = 1'b0;
      s_ld_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin s_ld_data = DW'($urandom); tick(); end
      check("small_ld_ready", s_ld_ready, 0);
      check("small_imem_we", s_imem_we, 0);
      check("small_cpu_reset", s_cpu_reset, 1);
      check("small_busy", s_busy, 1);
      check("small_load_err", s_load_err, 1);
      check("small_load_count", s_load_count, 8);
      s_ld_valid = 1'b0;
      check("small_nwrites", s_log.size(), 8);
      for (int i = 0; i < s_log.size(); i++) check("small_addr", s_log[i], i);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
